// File: rtl/font_writer.sv
// Byte-stream writer for the 2^(CHAR_BITS+3) x 8 font RAM: decodes {char, 8 rows} glyphs and bulk clears.
// Optional build macro FONT_WRITER_CHECKSUM_EN adds an XOR checksum of glyph row writes.
module font_writer #(
    parameter int         CHAR_BITS = 8,
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic                 i_px_clk,
    input  logic                 i_rstn,
    input  logic [7:0]           i_in_data,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic                 i_clear,
    output logic [CHAR_BITS+2:0] o_ram_addr,
    output logic [7:0]           o_ram_din,
    output logic                 o_ram_we,
    output logic                 o_busy,
    output logic                 o_glyph_done,
    output logic                 o_clear_done
`ifdef FONT_WRITER_CHECKSUM_EN
    ,
    output logic [7:0]           o_checksum
`endif
);

    localparam int ADDR_W = CHAR_BITS + 3;

    typedef enum logic [1:0] {
        GET_CHAR,
        GET_ROWS,
        CLEAR
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [CHAR_BITS-1:0]  r_charCode;
    logic [CHAR_BITS-1:0]  w_charCode;
    logic [2:0]            r_rowCnt;
    logic [2:0]            w_rowCnt;
    logic [ADDR_W-1:0]     r_ramAddr;
    logic [ADDR_W-1:0]     w_ramAddr;
    logic [7:0]            r_ramDin;
    logic [7:0]            w_ramDin;
    logic                  r_ramWe;
    logic                  w_ramWe;
    logic                  r_glyphDone;
    logic                  w_glyphDone;
    logic                  r_clearDone;
    logic                  w_clearDone;
    logic                  w_clearStart;
    logic                  w_accept;
    logic [ADDR_W-1:0]     w_clrNextAddr;

    assign o_in_ready    = (r_state != CLEAR);
    assign w_accept      = i_in_valid && o_in_ready;
    assign w_clrNextAddr = r_ramAddr + ADDR_W'(1);

    assign o_ram_addr   = r_ramAddr;
    assign o_ram_din    = r_ramDin;
    assign o_ram_we     = r_ramWe;
    assign o_busy       = (r_state == CLEAR);
    assign o_glyph_done = r_glyphDone;
    assign o_clear_done = r_clearDone;

    always_ff @(posedge i_px_clk) begin
        if (!i_rstn) begin
            r_state     <= GET_CHAR;
            r_charCode  <= '0;
            r_rowCnt    <= '0;
            r_ramAddr   <= '0;
            r_ramDin    <= '0;
            r_ramWe     <= 1'b0;
            r_glyphDone <= 1'b0;
            r_clearDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_charCode  <= w_charCode;
            r_rowCnt    <= w_rowCnt;
            r_ramAddr   <= w_ramAddr;
            r_ramDin    <= w_ramDin;
            r_ramWe     <= w_ramWe;
            r_glyphDone <= w_glyphDone;
            r_clearDone <= w_clearDone;
        end
    end

    // Clear writes address 0 on the sampling edge; the cycle after clear_done leaves CLEAR without a write.
    always_comb begin
        w_nextState  = r_state;
        w_charCode   = r_charCode;
        w_rowCnt     = r_rowCnt;
        w_ramAddr    = r_ramAddr;
        w_ramDin     = r_ramDin;
        w_ramWe      = 1'b0;
        w_glyphDone  = 1'b0;
        w_clearDone  = 1'b0;
        w_clearStart = 1'b0;

        if (i_clear) begin
            w_clearStart = 1'b1;
            w_nextState  = CLEAR;
            w_ramWe      = 1'b1;
            w_ramAddr    = '0;
            w_ramDin     = FILL_BYTE;
        end else begin
            case (r_state)
                GET_CHAR: begin
                    if (w_accept) begin
                        w_charCode  = CHAR_BITS'(i_in_data);
                        w_rowCnt    = 3'd0;
                        w_nextState = GET_ROWS;
                    end
                end
                GET_ROWS: begin
                    if (w_accept) begin
                        w_ramWe   = 1'b1;
                        w_ramAddr = {r_charCode, r_rowCnt};
                        w_ramDin  = i_in_data;
                        w_rowCnt  = r_rowCnt + 3'd1;
                        if (r_rowCnt == 3'd7) begin
                            w_glyphDone = 1'b1;
                            w_nextState = GET_CHAR;
                        end
                    end
                end
                CLEAR: begin
                    if (r_clearDone) begin
                        w_nextState = GET_CHAR;
                    end else begin
                        w_ramWe     = 1'b1;
                        w_ramAddr   = w_clrNextAddr;
                        w_ramDin    = FILL_BYTE;
                        w_clearDone = (w_clrNextAddr == {ADDR_W{1'b1}});
                    end
                end
                default: begin
                    w_nextState = GET_CHAR;
                end
            endcase
        end
    end

`ifdef FONT_WRITER_CHECKSUM_EN
    logic [7:0] r_checksum;

    assign o_checksum = r_checksum;

    // Any write seen outside CLEAR is a glyph row write.
    always_ff @(posedge i_px_clk) begin
        if (!i_rstn || w_clearStart) begin
            r_checksum <= 8'h00;
        end else if (r_ramWe && (r_state != CLEAR)) begin
            r_checksum <= r_checksum ^ r_ramDin;
        end
    end
`endif

endmodule

// File: tb/tb_font_writer.sv
// Directed bench for font_writer: glyph streaming, gapped input, bulk clear, clear abort and reset abort.
// Define FONT_WRITER_CHECKSUM_EN for both files to also exercise the checksum output.
module tb_font_writer;

    logic        i_px_clk;
    logic        i_rstn;
    logic [7:0]  i_in_data;
    logic        i_in_valid;
    logic        o_in_ready;
    logic        i_clear;
    logic [10:0] o_ram_addr;
    logic [7:0]  o_ram_din;
    logic        o_ram_we;
    logic        o_busy;
    logic        o_glyph_done;
    logic        o_clear_done;
`ifdef FONT_WRITER_CHECKSUM_EN
    logic [7:0]  o_checksum;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    font_writer #(
        .CHAR_BITS (8),
        .FILL_BYTE (8'h00)
    ) dut (
        .i_px_clk     (i_px_clk),
        .i_rstn       (i_rstn),
        .i_in_data    (i_in_data),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_clear      (i_clear),
        .o_ram_addr   (o_ram_addr),
        .o_ram_din    (o_ram_din),
        .o_ram_we     (o_ram_we),
        .o_busy       (o_busy),
        .o_glyph_done (o_glyph_done),
        .o_clear_done (o_clear_done)
`ifdef FONT_WRITER_CHECKSUM_EN
        ,
        .o_checksum   (o_checksum)
`endif
    );

    initial i_px_clk = 1'b0;
    always #5 i_px_clk = ~i_px_clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive inputs, advance one rising edge, then settle so outputs reflect that edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic clr);
        i_in_valid = valid;
        i_in_data  = data;
        i_clear    = clr;
        @(posedge i_px_clk);
        #1;
    endtask

    task automatic sendGlyph(input logic [7:0] ch, input logic [63:0] rows, input bit gaps, input logic [10:0] baseAddr);
        logic [7:0] rowByte;
        applyStimulus(1'b1, ch, 1'b0);
        checkOutput("charNoWrite", o_ram_we, 0);
        checkOutput("charReady", o_in_ready, 1);
        for (int i = 0; i < 8; i++) begin
            rowByte = rows[63 - 8*i -: 8];
            applyStimulus(1'b1, rowByte, 1'b0);
            checkOutput("rowWe", o_ram_we, 1);
            checkOutput("rowAddr", o_ram_addr, baseAddr + 11'(i));
            checkOutput("rowDin", o_ram_din, rowByte);
            checkOutput("rowGlyphDone", o_glyph_done, (i == 7) ? 1 : 0);
            checkOutput("rowReady", o_in_ready, 1);
            if (gaps) begin
                applyStimulus(1'b0, 8'hAA, 1'b0);
                checkOutput("gapNoWrite", o_ram_we, 0);
                checkOutput("gapGlyphDone", o_glyph_done, 0);
            end
        end
    endtask

    // Checks consecutive clear cycles showing addresses firstAddr..lastAddr.
    task automatic checkClearSweep(input int firstAddr, input int lastAddr);
        for (int k = firstAddr; k <= lastAddr; k++) begin
            checkOutput("clrWe", o_ram_we, 1);
            checkOutput("clrAddr", o_ram_addr, k);
            checkOutput("clrDin", o_ram_din, 8'h00);
            checkOutput("clrBusy", o_busy, 1);
            checkOutput("clrReady", o_in_ready, 0);
            checkOutput("clrDone", o_clear_done, (k == 2047) ? 1 : 0);
            checkOutput("clrGlyphDone", o_glyph_done, 0);
            if (k != lastAddr) applyStimulus(1'b0, 8'h00, 1'b0);
        end
    endtask

    initial begin
        i_rstn     = 1'b0;
        i_in_data  = 8'h00;
        i_in_valid = 1'b0;
        i_clear    = 1'b0;

        // Reset state
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rstWe", o_ram_we, 0);
        checkOutput("rstAddr", o_ram_addr, 0);
        checkOutput("rstDin", o_ram_din, 0);
        checkOutput("rstBusy", o_busy, 0);
        checkOutput("rstGlyphDone", o_glyph_done, 0);
        checkOutput("rstClearDone", o_clear_done, 0);
        checkOutput("rstReady", o_in_ready, 1);
        i_rstn = 1'b1;

        // Glyph 'A' streamed back to back
        sendGlyph(8'h41, 64'h1824_427E_4242_0000, 1'b0, 11'h208);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("idleWe", o_ram_we, 0);
        checkOutput("idleAddrHold", o_ram_addr, 11'h20F);
        checkOutput("idleDinHold", o_ram_din, 8'h00);
        checkOutput("idleGlyphDone", o_glyph_done, 0);

        // Same glyph with a gap cycle after every row
        sendGlyph(8'h41, 64'h1824_427E_4242_0000, 1'b1, 11'h208);

        // Full clear
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkClearSweep(0, 2047);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("postClrWe", o_ram_we, 0);
        checkOutput("postClrBusy", o_busy, 0);
        checkOutput("postClrReady", o_in_ready, 1);
        checkOutput("postClrDone", o_clear_done, 0);

        // Clear lands on the 4th row byte of glyph 0x7F, then restarts mid-clear
        applyStimulus(1'b1, 8'h7F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'h11 + 8'(i), 1'b0);
            checkOutput("abortRowAddr", o_ram_addr, 11'h3F8 + 11'(i));
            checkOutput("abortRowWe", o_ram_we, 1);
        end
        applyStimulus(1'b1, 8'h5A, 1'b1);
        checkClearSweep(0, 10);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkClearSweep(0, 2047);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("abortEndWe", o_ram_we, 0);
        checkOutput("abortEndGlyphDone", o_glyph_done, 0);
        checkOutput("abortEndReady", o_in_ready, 1);

        // Reset in the middle of a clear
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkClearSweep(0, 100);
        i_rstn = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("rstClrWe", o_ram_we, 0);
        checkOutput("rstClrBusy", o_busy, 0);
        checkOutput("rstClrReady", o_in_ready, 1);
        checkOutput("rstClrAddr", o_ram_addr, 0);
        i_rstn = 1'b1;
        sendGlyph(8'h05, 64'hF00F_AA55_C33C_FF81, 1'b0, 11'h028);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("afterRstIdleWe", o_ram_we, 0);

`ifdef FONT_WRITER_CHECKSUM_EN
        i_rstn = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("csumReset", o_checksum, 8'h00);
        i_rstn = 1'b1;
        sendGlyph(8'h10, 64'h0102_0408_1020_4080, 1'b0, 11'h080);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("csumGlyph", o_checksum, 8'hFF);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("csumClearStart", o_checksum, 8'h00);
        checkClearSweep(0, 2047);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("csumAfterClear", o_checksum, 8'h00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/font_writer.md
Name: font_writer

Overview:
- Writer side of the glyph store that the pixel renderer reads.
- Accepts a byte stream over a valid/ready handshake and decodes it into glyph-row writes on the font RAM write port. Each glyph is 1 character-code byte followed by 8 row bytes.
- Also provides a bulk clear that fills the whole RAM with a fill byte.
- Sits between the host/UART byte source and the write port of the 2^11 x 8 font RAM.

Parameters:
- CHAR_BITS, 8, width of character code; RAM address width = CHAR_BITS+3.
- FILL_BYTE, 8'h00, data written to every address during clear.

Ports:
- px_clk  input  1  pixel/system clock; all logic on rising edge.
- rstn  input  1  synchronous active-low reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  writer can accept a byte this cycle.
- clear  input  1  single-cycle pulse; start bulk clear.
- ram_addr  output  CHAR_BITS+3  write address {char, row[2:0]}.
- ram_din  output  8  write data; bit 7 = leftmost pixel (column 0).
- ram_we  output  1  write strobe, one cycle per write.
- busy  output  1  high while in CLEAR state.
- glyph_done  output  1  one-cycle pulse with the 8th row write of a glyph.
- clear_done  output  1  one-cycle pulse with the final clear write.

Behaviour:
- Reset (rstn=0 at an edge):
  - State goes to GET_CHAR.
  - ram_we=0, ram_addr=0, ram_din=0, busy=0, glyph_done=0, clear_done=0.
  - Row counter cleared; char register cleared.
  - Reset mid-glyph or mid-clear abandons the operation with no further writes.
- Handshake:
  - A byte is accepted on an edge where in_valid & in_ready.
  - in_ready is combinational from state: 1 in GET_CHAR and GET_ROWS, 0 in CLEAR.
  - in_data is ignored while in_valid=0.
- States:
  - GET_CHAR: an accepted byte is latched as the char code; row counter := 0; go to GET_ROWS. No RAM write.
  - GET_ROWS: an accepted byte produces a write on the next cycle: ram_we=1, ram_addr={char,row}, ram_din=byte. Row counter increments. The accept at row 7 returns to GET_CHAR and sets glyph_done=1 in the same cycle as that write.
  - CLEAR: entered on clear=1 from any state; clear has priority over a simultaneous byte accept, and the byte is not consumed (in_ready drops the next cycle). Issues one write per cycle, addr 0,1,...,2^(CHAR_BITS+3)-1, din=FILL_BYTE. clear_done=1 in the cycle with the last write; the next state is GET_CHAR. clear=1 during CLEAR restarts from address 0.
- Latency:
  - Write outputs are registered: exactly 1 cycle from accept to ram_we.
  - Back-to-back rows sustain 1 write per cycle.
  - The first clear write occurs the cycle after clear is sampled; a clear lasts 2^(CHAR_BITS+3) cycles (2048 by default).
- Idle outputs: ram_we=0 in every cycle without a write; ram_addr/ram_din hold their last value.
- Wrap-around:
  - The row counter is 3 bits and wraps 7→0 with the state change.
  - The clear address counter must detect its terminal count before wrapping; there is no write at address 0 after the final one.
- Aborted glyph (clear mid-glyph): rows already written remain until overwritten by the clear; the partial glyph gives no glyph_done.

Optional Feature:
- Macro: FONT_WRITER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[7:0]: XOR of every ram_din written by glyph writes since the last reset or clear. It updates in the same cycle as ram_we (value visible the cycle after the write).
  - Reset and the start of a clear set it to 0; clear writes do not contribute.
- When undefined: no checksum port and no associated logic.

Test Plan:
- Reset then stream 8'h41, 8'h18, 8'h24, 8'h42, 8'h7E, 8'h42, 8'h42, 8'h00, 8'h00 with in_valid held high → 8 consecutive ram_we cycles at addr 0x208..0x20F with those data; glyph_done only on the 0x20F write; in_ready stays 1.
- Same glyph with in_valid toggling 1/0 each cycle → identical writes, spaced 2 cycles apart; no write in gap cycles.
- clear pulse with FILL_BYTE=8'h00 → busy=1, in_ready=0 for 2048 cycles; writes addr 0..2047 data 0x00; clear_done with the addr 2047 write; then GET_CHAR with in_ready=1.
- clear asserted on the same edge as the 4th row byte of glyph 0x7F → no write for that byte; clear proceeds from addr 0; no glyph_done.
- rstn=0 during CLEAR at addr 100 → ram_we=0 the next cycle, busy=0; a subsequent glyph stream writes correctly.
- With FONT_WRITER_CHECKSUM_EN, glyph rows 0x01,0x02,0x04,0x08,0x10,0x20,0x40,0x80 → checksum=0xFF; after clear → 0x00.
